// File: rtl/c_rst_seq_pkg.sv
// Shared state codes and default timing constants for the reset sequencer,
// also used by the supervisor and top-level models.
package c_rst_seq_pkg;

  localparam logic [2:0] ST_HOLD    = 3'd0;
  localparam logic [2:0] ST_WAIT_PG = 3'd1;
  localparam logic [2:0] ST_SEQ     = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  localparam int DEF_N_STG  = 3;
  localparam int DEF_T_HOLD = 50;
  localparam int DEF_T_PG   = 1000;
  localparam int DEF_T_STG  = 100;
  localparam int DEF_T_DB   = 20;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/c_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to RST_VAL.
module c_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/c_rst_seq.sv
// Reset sequencer: holds all domain resets, waits for power-good, then
// releases N_STG resets in order with fixed spacing; ready in RUN, fault on pg timeout.
module c_rst_seq
  import c_rst_seq_pkg::*;
#(
  parameter int N_STG  = DEF_N_STG,
  parameter int T_HOLD = DEF_T_HOLD,
  parameter int T_PG   = DEF_T_PG,
  parameter int T_STG  = DEF_T_STG,
  parameter int T_DB   = DEF_T_DB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pb_n,
  input  logic             pg,
  output logic [N_STG-1:0] rst_out_n,
  output logic             ready,
  output logic             fault
);

  localparam int CW = $clog2(max4(T_HOLD, T_PG, T_STG, T_DB)) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] PG_LAST   = CW'(T_PG - 1);
  localparam logic [CW-1:0] STG_LAST  = CW'(T_STG - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(T_DB - 1);

  logic          rst_i_n;
  logic          pb_s;
  logic          pg_s;
  logic          press;
  logic          cause;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] cnt;
  logic [2:0]    state;

  // Assert asynchronously with rst_n, release two clocks later.
  c_sync2 #(.RST_VAL(1'b0)) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_i_n)
  );

  c_sync2 #(.RST_VAL(1'b1)) u_pb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pb_n),
    .q     (pb_s)
  );

  c_sync2 #(.RST_VAL(1'b0)) u_pg_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pg),
    .q     (pg_s)
  );

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      db_cnt <= '0;
      press  <= 1'b0;
    end else if (pb_s) begin
      db_cnt <= '0;
      press  <= 1'b0;
    end else if (db_cnt == DB_LAST) begin
      press  <= 1'b1;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  assign cause = press | ~pg_s;

  // rst_out_n is a thermometer code: each stage release shifts in a 1,
  // so the MSB doubles as the "last stage released" flag.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      rst_out_n <= '0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (press) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            state <= ST_WAIT_PG;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT_PG: begin
          if (press) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end else if (pg_s) begin
            state     <= ST_SEQ;
            cnt       <= '0;
            rst_out_n <= N_STG'(1);
          end else if (cnt == PG_LAST) begin
            state <= ST_FAULT;
            cnt   <= '0;
            fault <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SEQ: begin
          if (cause) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            rst_out_n <= '0;
          end else if (cnt == STG_LAST) begin
            cnt <= '0;
            if (rst_out_n[N_STG-1]) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end else begin
              rst_out_n <= (rst_out_n << 1) | N_STG'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (cause) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            rst_out_n <= '0;
            ready     <= 1'b0;
          end
        end
        ST_FAULT: begin
          if (press) begin
            state <= ST_HOLD;
            cnt   <= '0;
            fault <= 1'b0;
          end
        end
        default: begin
          state     <= ST_HOLD;
          cnt       <= '0;
          rst_out_n <= '0;
          ready     <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c_rst_seq.sv
// Scoreboard bench for c_rst_seq: default instance plus a 1-stage, T_STG=4 instance
// sharing all inputs; expectations are keyed to edges counted from reset release.
module tb_c_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       pb_n;
  logic       pg;
  logic [2:0] ro;
  logic       rdy;
  logic       flt;
  logic [0:0] ro1;
  logic       rdy1;
  logic       flt1;

  int ecount = 0;
  int base   = 0;
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    int         e;
    int         sel;
    logic [2:0] ro;
    logic       rdy;
    logic       flt;
    string      nm;
  } exp_t;

  exp_t sb[$];

  c_rst_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb_n      (pb_n),
    .pg        (pg),
    .rst_out_n (ro),
    .ready     (rdy),
    .fault     (flt)
  );

  c_rst_seq #(.N_STG(1), .T_STG(4)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb_n      (pb_n),
    .pg        (pg),
    .rst_out_n (ro1),
    .ready     (rdy1),
    .fault     (flt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  task automatic goto_edge(input int e);
    while (ecount - base < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int e, input int sel, input logic [2:0] r, input logic rd,
                      input logic f, input string nm);
    exp_t x;
    x.e = e; x.sel = sel; x.ro = r; x.rdy = rd; x.flt = f; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic apply_reset(input logic pg_v);
    rst_n = 1'b0;
    pb_n  = 1'b1;
    pg    = pg_v;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    base  = ecount;
  endtask

  task automatic test_reset();
    exp_t x;
    logic [4:0] act, req;
    rst_n = 1'b0;
    pb_n  = 1'b1;
    pg    = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++;
    if ({ro, rdy, flt, ro1, rdy1, flt1} !== 8'b0) begin
      $display("FAIL reset_hold: got %b want 00000000", {ro, rdy, flt, ro1, rdy1, flt1});
      n_fail++;
    end else n_pass++;
    rst_n = 1'b1;
    base  = ecount;
    push(1, 0, 3'b000, 0, 0, "edge1");
    push(2, 0, 3'b000, 0, 0, "edge2");
    push(2, 1, 3'b000, 0, 0, "edge2_n1");
    while (sb.size() > 0) begin
      x = sb.pop_front();
      goto_edge(x.e);
      act = (x.sel == 0) ? {ro, rdy, flt} : {2'b00, ro1, rdy1, flt1};
      req = {x.ro, x.rdy, x.flt};
      n_chk++;
      if (act !== req) begin
        $display("FAIL %s edge %0d dut%0d: got %b want %b", x.nm, x.e, x.sel, act, req);
        n_fail++;
      end else n_pass++;
    end
  endtask

  task automatic test_power_up();
    exp_t x;
    logic [4:0] act, req;
    push(52,  0, 3'b000, 0, 0, "pu_wait_pg");
    push(52,  1, 3'b000, 0, 0, "pu_n1_wait_pg");
    push(53,  0, 3'b001, 0, 0, "pu_stage0");
    push(53,  1, 3'b001, 0, 0, "pu_n1_stage0");
    push(56,  1, 3'b001, 0, 0, "pu_n1_pre_ready");
    push(57,  1, 3'b001, 1, 0, "pu_n1_ready");
    push(152, 0, 3'b001, 0, 0, "pu_pre_stage1");
    push(153, 0, 3'b011, 0, 0, "pu_stage1");
    push(252, 0, 3'b011, 0, 0, "pu_pre_stage2");
    push(253, 0, 3'b111, 0, 0, "pu_stage2");
    push(352, 0, 3'b111, 0, 0, "pu_pre_ready");
    push(353, 0, 3'b111, 1, 0, "pu_ready");
    while (sb.size() > 0) begin
      x = sb.pop_front();
      goto_edge(x.e);
      act = (x.sel == 0) ? {ro, rdy, flt} : {2'b00, ro1, rdy1, flt1};
      req = {x.ro, x.rdy, x.flt};
      n_chk++;
      if (act !== req) begin
        $display("FAIL %s edge %0d dut%0d: got %b want %b", x.nm, x.e, x.sel, act, req);
        n_fail++;
      end else n_pass++;
    end
  endtask

  task automatic test_bounce();
    exp_t x;
    logic [4:0] act, req;
    push(410, 0, 3'b111, 1, 0, "bounce1");
    push(430, 0, 3'b111, 1, 0, "bounce2");
    push(460, 0, 3'b111, 1, 0, "bounce3");
    push(460, 1, 3'b001, 1, 0, "bounce_n1");
    push(522, 0, 3'b111, 1, 0, "press_pre");
    push(523, 0, 3'b000, 0, 0, "press_assert");
    push(523, 1, 3'b000, 0, 0, "press_n1_assert");
    push(578, 0, 3'b000, 0, 0, "replay_wait_pg");
    push(579, 0, 3'b001, 0, 0, "replay_stage0");
    push(582, 1, 3'b001, 0, 0, "replay_n1_pre_ready");
    push(583, 1, 3'b001, 1, 0, "replay_n1_ready");
    push(678, 0, 3'b001, 0, 0, "replay_pre_stage1");
    push(679, 0, 3'b011, 0, 0, "replay_stage1");
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          goto_edge(400 + 20 * i); #1 pb_n = 1'b0;
          goto_edge(405 + 20 * i); #1 pb_n = 1'b1;
        end
        goto_edge(500); #1 pb_n = 1'b0;
        goto_edge(525); #1 pb_n = 1'b1;
      end
      begin
        while (sb.size() > 0) begin
          x = sb.pop_front();
          goto_edge(x.e);
          act = (x.sel == 0) ? {ro, rdy, flt} : {2'b00, ro1, rdy1, flt1};
          req = {x.ro, x.rdy, x.flt};
          n_chk++;
          if (act !== req) begin
            $display("FAIL %s edge %0d dut%0d: got %b want %b", x.nm, x.e, x.sel, act, req);
            n_fail++;
          end else n_pass++;
        end
      end
    join
  endtask

  task automatic test_pg_drop();
    exp_t x;
    logic [4:0] act, req;
    push(702, 0, 3'b011, 0, 0, "pgdrop_pre");
    push(702, 1, 3'b001, 1, 0, "pgdrop_n1_pre");
    push(703, 0, 3'b000, 0, 0, "pgdrop_assert");
    push(703, 1, 3'b000, 0, 0, "pgdrop_n1_assert");
    push(753, 0, 3'b000, 0, 0, "pgdrop_hold_end");
    push(754, 0, 3'b001, 0, 0, "pgdrop_stage0");
    push(757, 1, 3'b001, 0, 0, "pgdrop_n1_pre_ready");
    push(758, 1, 3'b001, 1, 0, "pgdrop_n1_ready");
    fork
      begin
        goto_edge(700); #1 pg = 1'b0;
        goto_edge(701); #1 pg = 1'b1;
      end
      begin
        while (sb.size() > 0) begin
          x = sb.pop_front();
          goto_edge(x.e);
          act = (x.sel == 0) ? {ro, rdy, flt} : {2'b00, ro1, rdy1, flt1};
          req = {x.ro, x.rdy, x.flt};
          n_chk++;
          if (act !== req) begin
            $display("FAIL %s edge %0d dut%0d: got %b want %b", x.nm, x.e, x.sel, act, req);
            n_fail++;
          end else n_pass++;
        end
      end
    join
  endtask

  task automatic test_rst_async();
    exp_t x;
    logic [4:0] act, req;
    goto_edge(800);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ro, rdy, flt, ro1, rdy1, flt1} !== 8'b0) begin
      $display("FAIL async_rst: got %b want 00000000", {ro, rdy, flt, ro1, rdy1, flt1});
      n_fail++;
    end else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base  = ecount;
    push(2,   0, 3'b000, 0, 0, "rerun_edge2");
    push(52,  0, 3'b000, 0, 0, "rerun_wait_pg");
    push(53,  0, 3'b001, 0, 0, "rerun_stage0");
    push(56,  1, 3'b001, 0, 0, "rerun_n1_pre_ready");
    push(57,  1, 3'b001, 1, 0, "rerun_n1_ready");
    push(153, 0, 3'b011, 0, 0, "rerun_stage1");
    push(253, 0, 3'b111, 0, 0, "rerun_stage2");
    push(352, 0, 3'b111, 0, 0, "rerun_pre_ready");
    push(353, 0, 3'b111, 1, 0, "rerun_ready");
    while (sb.size() > 0) begin
      x = sb.pop_front();
      goto_edge(x.e);
      act = (x.sel == 0) ? {ro, rdy, flt} : {2'b00, ro1, rdy1, flt1};
      req = {x.ro, x.rdy, x.flt};
      n_chk++;
      if (act !== req) begin
        $display("FAIL %s edge %0d dut%0d: got %b want %b", x.nm, x.e, x.sel, act, req);
        n_fail++;
      end else n_pass++;
    end
  endtask

  task automatic test_pg_fault();
    exp_t x;
    logic [4:0] act, req;
    apply_reset(1'b0);
    push(52,   0, 3'b000, 0, 0, "fault_wait_pg");
    push(1051, 0, 3'b000, 0, 0, "fault_pre");
    push(1052, 0, 3'b000, 0, 1, "fault_set");
    push(1052, 1, 3'b000, 0, 1, "fault_n1_set");
    push(1082, 0, 3'b000, 0, 1, "fault_press_pre");
    push(1083, 0, 3'b000, 0, 0, "fault_cleared");
    push(1142, 0, 3'b000, 0, 0, "fault_pg_pre");
    push(1143, 0, 3'b001, 0, 0, "fault_pg_stage0");
    push(1147, 1, 3'b001, 1, 0, "fault_n1_ready");
    fork
      begin
        goto_edge(1060); #1 pb_n = 1'b0;
        goto_edge(1080); #1 pb_n = 1'b1;
        goto_edge(1140); #1 pg = 1'b1;
      end
      begin
        while (sb.size() > 0) begin
          x = sb.pop_front();
          goto_edge(x.e);
          act = (x.sel == 0) ? {ro, rdy, flt} : {2'b00, ro1, rdy1, flt1};
          req = {x.ro, x.rdy, x.flt};
          n_chk++;
          if (act !== req) begin
            $display("FAIL %s edge %0d dut%0d: got %b want %b", x.nm, x.e, x.sel, act, req);
            n_fail++;
          end else n_pass++;
        end
      end
    join
  endtask

  task automatic test_timeout_tie();
    exp_t x;
    logic [4:0] act, req;
    apply_reset(1'b0);
    push(1051, 0, 3'b000, 0, 0, "tie_pre");
    push(1052, 0, 3'b001, 0, 0, "tie_pg_wins");
    push(1052, 1, 3'b001, 0, 0, "tie_n1_pg_wins");
    push(1056, 1, 3'b001, 1, 0, "tie_n1_ready");
    push(1152, 0, 3'b011, 0, 0, "tie_stage1");
    fork
      begin
        goto_edge(1049); #1 pg = 1'b1;
      end
      begin
        while (sb.size() > 0) begin
          x = sb.pop_front();
          goto_edge(x.e);
          act = (x.sel == 0) ? {ro, rdy, flt} : {2'b00, ro1, rdy1, flt1};
          req = {x.ro, x.rdy, x.flt};
          n_chk++;
          if (act !== req) begin
            $display("FAIL %s edge %0d dut%0d: got %b want %b", x.nm, x.e, x.sel, act, req);
            n_fail++;
          end else n_pass++;
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_bounce();
    test_pg_drop();
    test_rst_async();
    test_pg_fault();
    test_timeout_tie();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
